// File: rtl/ps2_note_scheduler_pkg.sv
// Shared constants and types for the PS/2 note scheduler: scan codes, note and
// FSM enums, the base half-period table and small decode helpers.
package ps2_note_pkg;

  localparam logic [7:0] SC_A    = 8'h1C;
  localparam logic [7:0] SC_B    = 8'h32;
  localparam logic [7:0] SC_C    = 8'h21;
  localparam logic [7:0] SC_D    = 8'h23;
  localparam logic [7:0] SC_E    = 8'h24;
  localparam logic [7:0] SC_F    = 8'h2B;
  localparam logic [7:0] SC_G    = 8'h34;
  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_UP   = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;

  typedef enum logic [2:0] {
    NOTE_A = 3'd0,
    NOTE_B = 3'd1,
    NOTE_C = 3'd2,
    NOTE_D = 3'd3,
    NOTE_E = 3'd4,
    NOTE_F = 3'd5,
    NOTE_G = 3'd6
  } note_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic  hit;
    note_t idx;
  } note_hit_t;

  // Entry 7 is unreachable; it repeats A so a 3-bit index never leaves the table.
  localparam logic [15:0] BASE_PERIOD [8] = '{
    16'd56818, 16'd50607, 16'd47801, 16'd42589,
    16'd37936, 16'd35817, 16'd31888, 16'd56818
  };

  function automatic note_hit_t decode_note(input logic [7:0] b);
    note_hit_t r;
    r.hit = 1'b1;
    r.idx = NOTE_A;
    case (b)
      SC_A:    r.idx = NOTE_A;
      SC_B:    r.idx = NOTE_B;
      SC_C:    r.idx = NOTE_C;
      SC_D:    r.idx = NOTE_D;
      SC_E:    r.idx = NOTE_E;
      SC_F:    r.idx = NOTE_F;
      SC_G:    r.idx = NOTE_G;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] lowest_index(input logic [6:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_note_scheduler_if.sv
// Byte-stream input and note-output bundle between the PS/2 front end, the
// scheduler and the tone generator.
interface ps2_note_if #(parameter int PERIOD_W = 20);
  import ps2_note_pkg::*;

  // byte_valid is a one-cycle strobe qualifying byte_data; there is no ready,
  // the scheduler accepts every byte, and all_off in the same cycle drops it.
  logic [7:0]          byte_data;
  logic                byte_valid;
  logic                all_off;
  logic                note_valid;
  logic [2:0]          note_index;
  logic signed [3:0]   octave;
  logic [PERIOD_W-1:0] half_period;
  logic                update;
  logic [6:0]          held;
  state_t              fsm_state;

  modport master (
    output byte_data, byte_valid, all_off,
    input  note_valid, note_index, octave, half_period, update, held, fsm_state
  );

  modport slave (
    input  byte_data, byte_valid, all_off,
    output note_valid, note_index, octave, half_period, update, held, fsm_state
  );

endinterface

// File: rtl/ps2_note_scheduler_lut.sv
// Maps a note index and signed octave offset to a half-period in clock cycles:
// positive octaves halve the base period per step, negative ones double it.
module note_period_lut
  import ps2_note_pkg::*;
#(
  parameter int PERIOD_W = 20
) (
  input  logic [2:0]          note_index,
  input  logic signed [3:0]   octave,
  output logic [PERIOD_W-1:0] half_period
);

  logic [PERIOD_W-1:0] base;
  logic [3:0]          mag;

  always_comb begin
    base        = PERIOD_W'(BASE_PERIOD[note_index]);
    mag         = octave[3] ? 4'(-octave) : 4'(octave);
    half_period = octave[3] ? (base << mag) : (base >> mag);
  end

endmodule

// File: rtl/ps2_note_scheduler.sv
// PS/2 set-2 decoder that tracks held note keys (A-G) and an arrow-key octave
// offset, and presents a registered half-period for the tone generator.
module ps2_note_scheduler
  import ps2_note_pkg::*;
#(
  parameter int PERIOD_W = 20,
  parameter int OCT_MAX  = 4
) (
  input  logic    CLOCK_50,
  input  logic    reset_n,
  ps2_note_if.slave bus
);

  localparam logic signed [3:0] OCT_HI = 4'(OCT_MAX);
  localparam logic signed [3:0] OCT_LO = -OCT_HI;

  state_t              state_q, state_d;
  logic [6:0]          held_q, held_d;
  logic                nv_q, nv_d;
  logic [2:0]          idx_q, idx_d;
  logic signed [3:0]   oct_q, oct_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic                update_q, update_d;
  note_hit_t           hit;
  logic [6:0]          remain;

  assign hit = decode_note(bus.byte_data);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      held_q   <= '0;
      nv_q     <= 1'b0;
      idx_q    <= 3'd0;
      oct_q    <= 4'sd0;
      hp_q     <= PERIOD_W'(BASE_PERIOD[0]);
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      nv_q     <= nv_d;
      idx_q    <= idx_d;
      oct_q    <= oct_d;
      hp_q     <= hp_d;
      update_q <= update_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    nv_d    = nv_q;
    idx_d   = idx_q;
    oct_d   = oct_q;
    remain  = held_q & ~(7'b1 << hit.idx);
    if (bus.all_off) begin
      state_d = IDLE;
      held_d  = '0;
      nv_d    = 1'b0;
      oct_d   = 4'sd0;
    end else if (bus.byte_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.byte_data == SC_EXT) begin
            state_d = EXT;
          end else if (bus.byte_data == SC_BRK) begin
            state_d = BRK;
          end else if (hit.hit && !held_q[hit.idx]) begin
            // A key that is already held is typematic repeat and changes nothing.
            held_d[hit.idx] = 1'b1;
            idx_d           = hit.idx;
            nv_d            = 1'b1;
          end
        end
        EXT: begin
          state_d = IDLE;
          if (bus.byte_data == SC_BRK) begin
            state_d = EXT_BRK;
          end else if (bus.byte_data == SC_UP && oct_q < OCT_HI) begin
            oct_d = oct_q + 4'sd1;
          end else if (bus.byte_data == SC_DOWN && oct_q > OCT_LO) begin
            oct_d = oct_q - 4'sd1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (hit.hit && held_q[hit.idx]) begin
            held_d = remain;
            if (remain == '0) begin
              nv_d = 1'b0;
            end else if (hit.idx == idx_q) begin
              idx_d = lowest_index(remain);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  note_period_lut #(.PERIOD_W(PERIOD_W)) u_lut (
    .note_index  (idx_d),
    .octave      (oct_d),
    .half_period (hp_d)
  );

  // Period-only changes while silent (octave moves with no key held) stay quiet.
  assign update_d = (nv_d != nv_q) | (nv_d & ((idx_d != idx_q) | (hp_d != hp_q)));

  assign bus.note_valid  = nv_q;
  assign bus.note_index  = idx_q;
  assign bus.octave      = oct_q;
  assign bus.half_period = hp_q;
  assign bus.update      = update_q;
  assign bus.held        = held_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_ps2_note_scheduler.sv
// Randomized and directed bench for ps2_note_scheduler against a key-set /
// prefix-queue model of the PS/2 note rules.
module tb_ps2_note_scheduler;
  import ps2_note_pkg::*;

  localparam int PERIOD_W = 20;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  ps2_note_if #(.PERIOD_W(PERIOD_W)) intf ();

  ps2_note_scheduler #(.PERIOD_W(PERIOD_W), .OCT_MAX(4)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (intf.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] codes [7]    = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34};
  int         base_tbl [7] = '{56818, 50607, 47801, 42589, 37936, 35817, 31888};
  bit         m_held [7];
  bit         m_nv  = 0;
  int         m_idx = 0;
  int         m_oct = 0;
  int         m_hp  = 56818;
  bit         m_upd = 0;
  logic [7:0] pfx_q [$];

  function automatic int note_of(input logic [7:0] b);
    for (int k = 0; k < 7; k++) if (codes[k] == b) return k;
    return -1;
  endfunction

  function automatic int period_of(input int idx, input int oct);
    if (oct > 0) return base_tbl[idx] / (1 << oct);
    if (oct < 0) return base_tbl[idx] * (1 << (-oct));
    return base_tbl[idx];
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    int any;
    k = note_of(b);
    if (pfx_q.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pfx_q.push_back(b);
      else if (k >= 0 && !m_held[k]) begin
        m_held[k] = 1; m_idx = k; m_nv = 1;
      end
    end else if (pfx_q.size() == 1 && pfx_q[0] == 8'hE0) begin
      pfx_q.delete();
      if (b == 8'hF0) begin
        pfx_q.push_back(8'hE0);
        pfx_q.push_back(8'hF0);
      end else if (b == 8'h75) m_oct = (m_oct < 4) ? m_oct + 1 : 4;
      else if (b == 8'h72) m_oct = (m_oct > -4) ? m_oct - 1 : -4;
    end else if (pfx_q.size() == 1) begin
      pfx_q.delete();
      if (k >= 0 && m_held[k]) begin
        m_held[k] = 0;
        any = -1;
        for (int j = 6; j >= 0; j--) if (m_held[j]) any = j;
        if (any < 0) m_nv = 0;
        else if (k == m_idx) m_idx = any;
      end
    end else begin
      pfx_q.delete();
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit p_nv;
    int p_idx;
    int p_hp;
    if (!reset_n) begin
      foreach (m_held[j]) m_held[j] = 0;
      m_nv = 0; m_idx = 0; m_oct = 0; m_hp = 56818; m_upd = 0;
      pfx_q.delete();
    end else begin
      p_nv = m_nv; p_idx = m_idx; p_hp = m_hp;
      if (intf.all_off) begin
        foreach (m_held[j]) m_held[j] = 0;
        m_nv = 0; m_oct = 0;
        pfx_q.delete();
      end else if (intf.byte_valid) begin
        model_byte(intf.byte_data);
      end
      m_hp  = period_of(m_idx, m_oct);
      m_upd = (m_nv != p_nv) || (m_nv && (m_idx != p_idx || m_hp != p_hp));
    end
  end

  // scoreboard
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] mh;
    for (int j = 0; j < 7; j++) mh[j] = m_held[j];
    chk("held",        intf.held, mh);
    chk("note_valid",  intf.note_valid, m_nv);
    chk("note_index",  intf.note_index, m_idx);
    chk("octave",      $signed(intf.octave), m_oct);
    chk("half_period", intf.half_period, m_hp);
    chk("update",      intf.update, m_upd);
  end

  // driver tasks
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    intf.byte_data  = b;
    intf.byte_valid = 1'b1;
    @(posedge clk); #1;
    intf.byte_valid = 1'b0;
  endtask

  task automatic pulse_all_off();
    @(posedge clk); #1;
    intf.all_off = 1'b1;
    @(posedge clk); #1;
    intf.all_off = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pick [12] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                              8'hE0, 8'hF0, 8'h75, 8'h72, 8'h00};
    reset_n         = 1'b0;
    intf.byte_data  = 8'h00;
    intf.byte_valid = 1'b0;
    intf.all_off    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held", intf.held, 0);
    chk("rst_nv", intf.note_valid, 0);
    chk("rst_hp", intf.half_period, 56818);
    chk("rst_upd", intf.update, 0);
    reset_n = 1'b1;

    send(8'h1C);
    chk("a_nv", intf.note_valid, 1);
    chk("a_idx", intf.note_index, 0);
    chk("a_hp", intf.half_period, 56818);
    chk("a_upd", intf.update, 1);
    chk("a_held", intf.held, 7'b0000001);

    send(8'h34);
    chk("g_idx", intf.note_index, 6);
    send(8'hF0); send(8'h34);
    chk("relg_idx", intf.note_index, 0);
    chk("relg_hp", intf.half_period, 56818);
    chk("relg_held", intf.held, 7'b0000001);
    send(8'hF0); send(8'h1C);
    chk("rela_nv", intf.note_valid, 0);
    chk("rela_held", intf.held, 0);

    pulse_all_off();
    repeat (5) begin send(8'hE0); send(8'h75); end
    chk("oct_hi", $signed(intf.octave), 4);
    send(8'h24);
    chk("e_hi_hp", intf.half_period, 2371);
    repeat (9) begin send(8'hE0); send(8'h72); end
    chk("oct_lo", $signed(intf.octave), -4);
    chk("e_lo_hp", intf.half_period, 606976);

    pulse_all_off();
    send(8'h21);
    chk("c1_upd", intf.update, 1);
    chk("c1_idx", intf.note_index, 2);
    chk("c1_hp", intf.half_period, 47801);
    send(8'h21);
    chk("c2_upd", intf.update, 0);
    send(8'h21);
    chk("c3_upd", intf.update, 0);

    pulse_all_off();
    send(8'hE0);
    pulse_reset();
    chk("mid_rst_nv", intf.note_valid, 0);
    send(8'h1C);
    chk("post_rst_nv", intf.note_valid, 1);
    chk("post_rst_idx", intf.note_index, 0);
    chk("post_rst_oct", $signed(intf.octave), 0);

    pulse_all_off();
    send(8'hE0); send(8'h75);
    send(8'h23);
    chk("d_idx", intf.note_index, 3);
    @(posedge clk); #1;
    intf.all_off    = 1'b1;
    intf.byte_valid = 1'b1;
    intf.byte_data  = 8'h1C;
    @(posedge clk); #1;
    intf.all_off    = 1'b0;
    intf.byte_valid = 1'b0;
    chk("ao_held", intf.held, 0);
    chk("ao_nv", intf.note_valid, 0);
    chk("ao_oct", $signed(intf.octave), 0);
    chk("ao_hp", intf.half_period, 42589);
    chk("ao_upd", intf.update, 1);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 400) == 0) begin
        reset_n         = 1'b0;
        intf.byte_valid = 1'b0;
        intf.all_off    = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
      end else begin
        int sel;
        sel             = $urandom_range(0, 13);
        intf.byte_valid = ($urandom_range(0, 2) == 0);
        intf.byte_data  = (sel < 12) ? pick[sel] : 8'($urandom_range(0, 255));
        intf.all_off    = ($urandom_range(0, 80) == 0);
      end
    end
    @(posedge clk); #1;
    intf.byte_valid = 1'b0;
    intf.all_off    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_note_scheduler.md
Name: ps2_note_scheduler

Overview:
- Sits between PS2_Controller (received_data / received_data_en byte stream) and the square-wave tone generator feeding Audio_Controller.
- Decodes PS/2 set-2 make, break and extended sequences, and tracks which of the seven note keys (A–G) are held.
- Maintains a saturating signed octave offset driven by the up/down arrow keys.
- Emits a registered half-period and a note-valid flag, so a tone only sounds while a note key is held.

Parameters:
- PERIOD_W, 20, width of half_period; holds the largest value, base A << 4 = 909088.
- OCT_MAX, 4, octave offset saturates to the range -OCT_MAX..+OCT_MAX.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- byte_data  in  8  PS/2 byte from PS2_Controller.received_data.
- byte_valid  in  1  one-cycle strobe; byte_data is valid when high.
- all_off  in  1  synchronous one-cycle pulse; releases all notes and clears the octave.
- note_valid  out  1  high while at least one note key is held.
- note_index  out  3  current note: A=0, B=1, C=2, D=3, E=4, F=5, G=6.
- octave  out  4  signed octave offset, two's complement.
- half_period  out  PERIOD_W  CLOCK_50 cycles per half wave of the current note.
- update  out  1  one-cycle pulse whenever note_valid, note_index or half_period changes.
- held  out  7  bitmask of held note keys; bit i corresponds to note_index i.

Behaviour:
- Reset values (async, active-low): FSM=IDLE, held=0, note_valid=0, note_index=0, octave=0, half_period=56818, update=0.
- FSM advances only on byte_valid.
  - IDLE: E0 -> EXT; F0 -> BRK; note make -> MAKE action; any other byte -> stay in IDLE, no effect.
  - EXT: F0 -> EXT_BRK; 75 -> octave+1, saturating at +OCT_MAX; 72 -> octave-1, saturating at -OCT_MAX; any other byte -> IDLE, ignored. Every exit except F0 returns to IDLE.
  - BRK: the next byte is a break code. A note code triggers the RELEASE action; any other byte is ignored. Return to IDLE.
  - EXT_BRK: the next byte is consumed and ignored (arrow break codes have no effect). Return to IDLE.
- Note scan codes: A=1C, B=32, C=21, D=23, E=24, F=2B, G=34.
- MAKE action (key i):
  - If held[i] was already 1 (typematic repeat): no change, no update pulse.
  - Otherwise: set held[i], note_index<=i, note_valid<=1.
- RELEASE action (key i):
  - Clear held[i].
  - If i==note_index: note_index <= lowest set index among the remaining held bits.
  - If no keys remain: note_valid<=0 and note_index is unchanged.
  - Releasing a key that is not held: no effect.
- half_period (registered, recomputed from the new note_index and octave):
  - Base table: A 56818, B 50607, C 47801, D 42589, E 37936, F 35817, G 31888.
  - octave>0: base >> octave. octave<0: base << -octave. octave=0: base.
  - No overflow is possible within ±4.
- Octave changes recompute half_period even when note_valid=0. They pulse update only if note_valid=1.
- Latency: every output reflects the effect of a byte on the cycle after its byte_valid; update pulses on that same cycle.
- all_off:
  - Next cycle: FSM=IDLE, held=0, note_valid=0, octave=0, half_period recomputed at octave 0.
  - Pulses update if note_valid was 1.
  - If all_off coincides with byte_valid, all_off wins and the byte is dropped.
- Reset asserted mid-sequence (e.g. after E0): returns to IDLE, and the partial sequence is discarded.

Decomposition:
- Package ps2_note_pkg holds:
  - scan-code constants (note codes, E0, F0, UP=75, DOWN=72);
  - note index enum A..G = 0..6;
  - FSM state enum IDLE, EXT, BRK, EXT_BRK;
  - base half-period constant array.
- One sub-module, note_period_lut: combinational; inputs note_index and octave, output shifted half_period.

Test Plan:
- Reset, then bytes 1C -> next cycle note_valid=1, note_index=0, half_period=56818, update=1, held=0000001.
- 1C, 34, F0 34 -> after F0 34: note_index=0, half_period=56818, held=0000001. Then F0 1C -> note_valid=0, held=0.
- E0 75 ×5, then 24 -> octave=+4 (saturated), half_period=37936>>4=2371. Then E0 72 ×9 -> octave=-4, half_period=606976.
- 21, 21, 21 (typematic repeat) -> only one update pulse; note_index=2, half_period=47801.
- E0 then reset_n low for one cycle, then 1C -> IDLE after reset; 1C is decoded as note A and the octave stays 0.
- all_off asserted on the same cycle as byte_valid with 1C, while note D is held -> next cycle held=0, note_valid=0, octave=0; the 1C byte is dropped.
